// File: rtl/pe_pkg.sv
// Shared types and constants for the PE controller memory read responders.
package pe_pkg;

  localparam int ADDR_IN_W      = 17;
  localparam int DATA_W         = 128;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STALL} rd_state_t;

  typedef logic [ADDR_IN_W-1:0] pe_addr_t;

  // Left shift that turns a word address into a byte address.
  function automatic int word_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/pe_req_fifo.sv
// Small synchronous request queue of word addresses with a single-cycle flush.
module pe_req_fifo
  import pe_pkg::*;
#(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/pe_read_master.sv
// Read responder for one PE controller stream: turns word-address requests into
// Avalon-MM reads with a bounded number of outstanding transactions.
module pe_read_master #(
  parameter int                    ADDR_IN_W  = pe_pkg::ADDR_IN_W,
  parameter int                    AVM_ADDR_W = 32,
  parameter int                    DATA_W     = pe_pkg::DATA_W,
  parameter logic [AVM_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                    QDEPTH     = 4,
  parameter int                    MAX_PEND   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  master_en,
  input  logic [ADDR_IN_W-1:0]  addr_pe,
  output logic [DATA_W-1:0]     readdata_pe,
  output logic                  readdatavalid,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  busy
);

  import pe_pkg::*;

  localparam int             SHIFT = word_shift(DATA_W);
  localparam int             PW    = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0]  MAX_P = PW'(MAX_PEND);

  function automatic logic [AVM_ADDR_W-1:0] byte_addr(input logic [ADDR_IN_W-1:0] a);
    return BASE_ADDR + (AVM_ADDR_W'(a) << SHIFT);
  endfunction

  rd_state_t             state, state_nxt;
  logic [PW-1:0]         pend_cnt, pend_nxt;
  logic                  en_d;
  logic [ADDR_IN_W-1:0]  last_addr;
  logic                  overflow;
  logic                  capture, push, flush, load, accept, dec, q_avail;
  logic                  q_full, q_empty;
  logic [ADDR_IN_W-1:0]  q_head;
  logic [DATA_W-1:0]     rdata_p1;
  logic                  vld_p1;

  assign capture = master_en && (!en_d || (addr_pe != last_addr));
  assign push    = capture && !q_full;
  assign flush   = en_d && !master_en;
  assign accept  = avm_read && !avm_waitrequest;
  assign dec     = avm_readdatavalid && (pend_cnt != '0);
  // An entry popped in the flush cycle would be un-issued work, so hold off.
  assign q_avail = !q_empty && !flush;

  // The queue only holds un-issued addresses; an entry leaves when it is driven on the bus.
  pe_req_fifo #(.W(ADDR_IN_W), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (addr_pe),
    .pop   (load),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    pend_nxt = pend_cnt;
    if (accept && !dec)      pend_nxt = pend_cnt + 1'b1;
    else if (!accept && dec) pend_nxt = pend_cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (q_avail) begin
          if (pend_cnt < MAX_P) begin
            load      = 1'b1;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_STALL;
          end
        end
      end
      S_REQ: begin
        if (accept) begin
          if (q_avail && (pend_nxt < MAX_P)) load = 1'b1;
          else if (q_avail)                  state_nxt = S_STALL;
          else                               state_nxt = S_IDLE;
        end
      end
      S_STALL: begin
        if (pend_cnt < MAX_P) begin
          if (q_avail) begin
            load      = 1'b1;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: request issue, bookkeeping and registered return path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pend_cnt    <= '0;
      en_d        <= 1'b0;
      last_addr   <= '0;
      overflow    <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= '0;
      vld_p1      <= 1'b0;
      rdata_p1    <= '0;
    end else begin
      state    <= state_nxt;
      pend_cnt <= pend_nxt;
      en_d     <= master_en;
      if (push)             last_addr <= addr_pe;
      if (capture && q_full) overflow <= 1'b1;
      if (load) begin
        avm_read    <= 1'b1;
        avm_address <= byte_addr(q_head);
      end else if (accept) begin
        avm_read <= 1'b0;
      end
      vld_p1   <= dec;
      rdata_p1 <= avm_readdata;
    end
  end

  assign readdata_pe   = rdata_p1;
  assign readdatavalid = vld_p1;
  assign busy          = !q_empty || (pend_cnt != '0) || avm_read;

  // The controller cadence never overruns the queue; a dropped request is a system fault.
  ovf_never: assert property (@(posedge clk) disable iff (rst) !overflow);

endmodule
